bkm_ctrl: RTL and testbench

- Iteration sequencer and digit-selection unit that sits directly upstream of bkm_step.
- Runs N BKM iterations per operation. For each iteration it drives the step index n and the digit d_n to bkm_step, and qualifies bkm_step's enable.
- Selects d_n from the u_n/v_n remainder that bkm_step registers and feeds back.
- Handshake with the FPU top level is start/busy/done.

---
 rtl/bkm_ctrl.sv | 143 ++++++++++++++
 tb/tb_bkm_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_ctrl.sv
// BKM iteration sequencer and digit-selection unit feeding bkm_step.
// Define BKM_CTRL_ABORT_EN to add the abort input and aborted pulse output.
module bkm_ctrl #(
  parameter int W     = 8,
  parameter int LOG2W = 3,
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int THR   = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       format,
`ifdef BKM_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic [W-1:0]     u_n,
  input  logic [W-1:0]     v_n,
  output logic [LOG2N-1:0] n,
  output logic [3:0]       d_n,
  output logic             mode_o,
  output logic [1:0]       format_o,
  output logic             load,
  output logic             step_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEL, S_STEP, S_DONE} state_t;

  // Compare width comes from LOG2W; W is expected to equal 2**LOG2W.
  localparam int XW = 1 << LOG2W;
  localparam logic signed [XW-1:0] THR_P  = XW'(THR);
  localparam logic signed [XW-1:0] THR_N  = -THR_P;
  localparam logic [LOG2N-1:0]     N_LAST = LOG2N'(N - 1);

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;

  state_t state, state_nx;
  logic signed [XW-1:0] u_s, v_s;
  logic [1:0] d_re, d_im;
  logic abort_hit;

  assign u_s = u_n;
  assign v_s = v_n;

`ifdef BKM_CTRL_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [1:0] sel(input logic signed [XW-1:0] x);
    if (x >= THR_P)     sel = DIG_POS;
    else if (x < THR_N) sel = DIG_NEG;
    else                sel = DIG_ZERO;
  endfunction

  // Negating the digit rather than x keeps -2^(W-1) free of overflow.
  function automatic logic [1:0] neg(input logic [1:0] d);
    case (d)
      DIG_POS: neg = DIG_NEG;
      DIG_NEG: neg = DIG_POS;
      default: neg = DIG_ZERO;
    endcase
  endfunction

  always_comb begin
    d_re = sel(u_s);
    d_im = sel(v_s);
    if (mode_o) begin
      d_re = neg(d_re);
      d_im = neg(d_im);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!srst)       state <= S_IDLE;
    else if (enable) state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_SEL;
      S_SEL:  state_nx = S_STEP;
      S_STEP: state_nx = (n == N_LAST) ? S_DONE : S_SEL;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_hit) state_nx = S_IDLE;
  end

  // Outputs decode from state alone, so a frozen state freezes them too.
  always_comb begin
    load    = (state == S_LOAD);
    step_en = (state == S_STEP);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      n        <= '0;
      d_n      <= '0;
      mode_o   <= 1'b0;
      format_o <= 2'b00;
    end else if (enable) begin
      case (state)
        S_IDLE: if (start) begin
          n        <= '0;
          mode_o   <= mode;
          format_o <= format;
        end
        S_SEL:  d_n <= {d_re, d_im};
        S_STEP: if (n != N_LAST) n <= n + LOG2N'(1);
        default: ;
      endcase
      if (abort_hit) begin
        n   <= '0;
        d_n <= '0;
      end
    end
  end

`ifdef BKM_CTRL_ABORT_EN
  always_ff @(posedge clk) begin
    if (!srst)       aborted <= 1'b0;
    else if (enable) aborted <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_bkm_ctrl.sv
// Randomized scoreboard bench for bkm_ctrl: stimulus pushes expected
// load/step/done events, a negedge monitor pops and compares them.
module tb_bkm_ctrl;
  localparam int W     = 8;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int THR   = 16;

  logic clk = 1'b0, srst = 1'b0, enable = 1'b0, start = 1'b0, mode = 1'b0;
  logic [1:0] format = 2'b00;
  logic [W-1:0] u_n = '0, v_n = '0;
  logic [LOG2N-1:0] n;
  logic [3:0] d_n;
  logic mode_o, load, step_en, busy, done;
  logic [1:0] format_o;
`ifdef BKM_CTRL_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  bkm_ctrl #(.W(W), .LOG2W(3), .N(N), .LOG2N(LOG2N), .THR(THR)) dut (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .mode(mode),
    .format(format),
`ifdef BKM_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .u_n(u_n), .v_n(v_n), .n(n), .d_n(d_n), .mode_o(mode_o),
    .format_o(format_o), .load(load), .step_en(step_en), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 load, 1 step, 2 done
    int n;
    int d;
    int md;
    int fmt;
    int due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference digit rule in plain integer arithmetic.
  function automatic int sel_m(input logic [W-1:0] x);
    int xi;
    xi = int'($signed(x));
    if (xi >= THR)  return 1;
    if (xi < -THR)  return -1;
    return 0;
  endfunction

  function automatic int enc(input int dg);
    if (dg == 1)  return 1;
    if (dg == -1) return 3;
    return 0;
  endfunction

  function automatic int digit_pair(input bit md, input logic [W-1:0] u, input logic [W-1:0] v);
    int r, i;
    r = sel_m(u);
    i = sel_m(v);
    if (md) begin
      r = -r;
      i = -i;
    end
    return enc(r) * 4 + enc(i);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_n"}, 32'(n), 0);
    check({tag, "_d_n"}, 32'(d_n), 0);
    check({tag, "_mode_o"}, 32'(mode_o), 0);
    check({tag, "_format_o"}, 32'(format_o), 0);
    check({tag, "_load"}, 32'(load), 0);
    check({tag, "_step_en"}, 32'(step_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_on && enable && (load || step_en || done)) begin
      mon_kind = load ? 0 : (step_en ? 1 : 2);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", mon_kind, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
        check("event_cycle", 32'(cyc), 32'(mon_e.due));
        check("event_busy", 32'(busy), 1);
        if (mon_e.kind == 0) check("load_n", 32'(n), 0);
        if (mon_e.kind == 1) begin
          check("step_n", 32'(n), 32'(mon_e.n));
          check("step_d_n", 32'(d_n), 32'(mon_e.d));
          check("step_mode_o", 32'(mode_o), 32'(mon_e.md));
          check("step_format_o", 32'(format_o), 32'(mon_e.fmt));
        end
      end
    end
  end

  // fi/flen: freeze enable for flen edges during STEP n=fi.
  // ri: reset during STEP n=ri.  ai: abort during STEP n=ai.
  task automatic run_op(input bit md, input logic [1:0] fm, input int u, input int v,
                        input int fi, input int flen, input int ri, input int ai);
    int k, dd, d, c, ext;
    logic [W-1:0] ub, vb;
    ub = W'(u);
    vb = W'(v);
    @(posedge clk); #1;
    start = 1'b1; mode = md; format = fm; u_n = ub; v_n = vb; enable = 1'b1;
    k = cyc + 1;
    d = digit_pair(md, ub, vb);
    sb.push_back('{0, 0, 0, int'(md), int'(fm), k});
    for (int i = 0; i < N; i++) begin
      if ((ri >= 0 && i > ri) || (ai >= 0 && i > ai)) break;
      ext = (fi >= 0 && i >= fi) ? flen : 0;
      sb.push_back('{1, i, d, int'(md), int'(fm), k + 2 + 2 * i + ext});
    end
    dd = k + 2 * N + 1 + ((fi >= 0) ? flen : 0);
    if (ri < 0 && ai < 0) sb.push_back('{2, 0, 0, int'(md), int'(fm), dd});

    for (int t = 0; t < 4 * N + 64; t++) begin
      @(posedge clk); #1;
      c = cyc;
      mode   = 1'($urandom_range(0, 1));
      format = 2'($urandom_range(0, 3));
      enable = !(fi >= 0 && c >= k + 2 + 2 * fi && c < k + 2 + 2 * fi + flen);
      if (c < dd)       start = 1'($urandom_range(0, 1));
      else if (c == dd) start = 1'b1;
      else              start = 1'b0;
      if (ri >= 0 && c == k + 2 + 2 * ri) begin
        srst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midop_reset");
        srst = 1'b1;
        repeat (4) @(posedge clk);
        break;
      end
`ifdef BKM_CTRL_ABORT_EN
      if (ai >= 0 && c == k + 2 + 2 * ai) begin
        abort = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_pulse", 32'(aborted), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_n", 32'(n), 0);
        check("abort_d_n", 32'(d_n), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clk);
        check("abort_pulse_end", 32'(aborted), 0);
        repeat (4) @(posedge clk);
        break;
      end
`endif
      if (c == dd + 1) begin
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        break;
      end
    end
    check("sb_drain", 32'(sb.size()), 0);
    sb.delete();
  endtask

  int pool[8] = '{16, 15, -16, -17, -128, 127, 0, 20};

  function automatic int pick();
    if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 7)];
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    srst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      start  = 1'b1;
      enable = 1'($urandom_range(0, 1));
      mode   = 1'($urandom_range(0, 1));
      format = 2'($urandom_range(0, 3));
      u_n    = W'($urandom_range(0, 255));
      v_n    = W'($urandom_range(0, 255));
    end
    @(negedge clk);
    check_reset_outputs("reset");
    srst = 1'b1; start = 1'b0; enable = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("start_during_reset_ignored", 32'(busy), 0);

    run_op(1'b0, 2'b01,   20,  -20, -1, 0, -1, -1);
    run_op(1'b1, 2'b10,   16,  -16, -1, 0, -1, -1);
    run_op(1'b1, 2'b11,  -17,   15, -1, 0, -1, -1);
    run_op(1'b1, 2'b00, -128,    0, -1, 0, -1, -1);
    run_op(1'b0, 2'b01, -128,  127, -1, 0, -1, -1);
    run_op(1'b0, 2'b10,   20,  -20,  3, 5, -1, -1);
    run_op(1'b1, 2'b01,  -40,   33, -1, 0,  5, -1);
    run_op(1'b0, 2'b11,   17,  -17, -1, 0, -1, -1);
`ifdef BKM_CTRL_ABORT_EN
    run_op(1'b0, 2'b01,   20,  -20, -1, 0, -1,  2);
    run_op(1'b1, 2'b10,  -20,   20, -1, 0, -1, -1);
`endif
    for (int r = 0; r < 10; r++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick(), pick(),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
             int'($urandom_range(1, 4)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before time 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
